// File: rtl/time_digit_writer.sv
// ---------------------------------------------------------------------------
// time_digit_writer
//
// Purpose:
//   Consumer side of the clock-time update interface. Each digit flagged in
//   an update mask becomes one glyph-draw request for the LCD draw engine.
//   Requests are issued left-most digit first (H2 .. S1) over a valid/ready
//   handshake. Updates that arrive while a scan is running are merged into a
//   pending mask, so no digit change is lost.
//
// Ports:
//   i_clk             clock
//   i_rst             asynchronous reset, active-high
//   i_time_wr_en      one-cycle update strobe
//   i_time_sel[5:0]   digit-changed mask (bit0=S1 .. bit5=H2)
//   i_time_read_time  packed BCD time word (20 bits)
//   i_force_all       one-cycle request to redraw all six digits
//   i_draw_ready      draw engine accepts the current request
//   o_draw_valid      request valid
//   o_draw_idx[2:0]   digit index, same numbering as the mask
//   o_draw_value[3:0] digit value, zero-extended
//   o_draw_x[X_W-1:0] glyph x-coordinate
//   o_busy            scan active or pending work held
//   o_frame_done      one-cycle pulse after the last request of a chain
// ---------------------------------------------------------------------------
module time_digit_writer #(
    parameter int X_W         = 8,
    parameter int DIGIT_X0    = 8,
    parameter int DIGIT_PITCH = 12,
    parameter int COLON_GAP   = 6
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_time_wr_en,
    input  logic [5:0]     i_time_sel,
    input  logic [19:0]    i_time_read_time,
    input  logic           i_force_all,
    input  logic           i_draw_ready,
    output logic           o_draw_valid,
    output logic [2:0]     o_draw_idx,
    output logic [3:0]     o_draw_value,
    output logic [X_W-1:0] o_draw_x,
    output logic           o_busy,
    output logic           o_frame_done
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_active;
    logic [5:0]  r_pending;
    logic [19:0] r_snap;
    logic [19:0] r_pend_snap;
    logic        r_frame_done;

    logic [5:0]  w_active_nxt;
    logic [5:0]  w_pending_nxt;
    logic [19:0] w_snap_nxt;
    logic [19:0] w_pend_snap_nxt;
    logic        w_frame_done_nxt;

    logic [5:0]  w_evt_mask;
    logic        w_evt;
    logic [2:0]  w_idx;
    logic [5:0]  w_digit_bit;
    logic [5:0]  w_remaining;
    logic [5:0]  w_merged_pend;
    logic [19:0] w_merged_snap;
    logic        w_hs;
    logic [3:0]  w_value;

    // Screen position of a digit; p counts from the left, and each colon
    // adds an extra gap after the hours pair and after the minutes pair.
    function automatic logic [X_W-1:0] digitX(input logic [2:0] idx);
        int p;
        int s;
        p = 5 - int'(idx);
        s = DIGIT_X0 + p * DIGIT_PITCH;
        if (p >= 2) s = s + COLON_GAP;
        if (p >= 4) s = s + COLON_GAP;
        return X_W'(s);
    endfunction

    // Event mask combines the update strobe and the full-redraw request.
    always_comb begin
        w_evt_mask = (i_time_wr_en ? i_time_sel : 6'h00) |
                     (i_force_all  ? 6'h3F      : 6'h00);
        w_evt      = |w_evt_mask;
    end

    // Highest set bit of the active mask wins, so H2 goes out first.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (r_active[i]) w_idx = 3'(i);
        end
    end

    // Digit value from the snapshot; short fields are zero-extended and
    // out-of-range BCD is passed through untouched.
    always_comb begin
        w_value = 4'd0;
        case (w_idx)
            3'd0: w_value = r_snap[3:0];
            3'd1: w_value = {1'b0, r_snap[6:4]};
            3'd2: w_value = r_snap[10:7];
            3'd3: w_value = {1'b0, r_snap[13:11]};
            3'd4: w_value = r_snap[17:14];
            3'd5: w_value = {2'b00, r_snap[19:18]};
            default: w_value = 4'd0;
        endcase
    end

    // Handshake bookkeeping; a same-cycle event is folded into pending
    // before deciding whether the chain continues.
    always_comb begin
        w_digit_bit   = 6'b000001 << w_idx;
        w_remaining   = r_active & ~w_digit_bit;
        w_hs          = (r_state == SEND) && i_draw_ready;
        w_merged_pend = r_pending | w_evt_mask;
        w_merged_snap = w_evt ? i_time_read_time : r_pend_snap;
    end

    // Next-state and datapath-next logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_active_nxt     = r_active;
        w_pending_nxt    = r_pending;
        w_snap_nxt       = r_snap;
        w_pend_snap_nxt  = r_pend_snap;
        w_frame_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_evt) begin
                    w_active_nxt = w_evt_mask;
                    w_snap_nxt   = i_time_read_time;
                    w_state_nxt  = SEND;
                end
            end
            SEND: begin
                w_pending_nxt   = w_merged_pend;
                w_pend_snap_nxt = w_merged_snap;
                if (w_hs) begin
                    if (w_remaining != 6'h00) begin
                        w_active_nxt = w_remaining;
                    end else if (w_merged_pend != 6'h00) begin
                        w_active_nxt  = w_merged_pend;
                        w_snap_nxt    = w_merged_snap;
                        w_pending_nxt = 6'h00;
                    end else begin
                        w_active_nxt     = 6'h00;
                        w_state_nxt      = IDLE;
                        w_frame_done_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any scan in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Masks, snapshots and the frame-done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active     <= 6'h00;
            r_pending    <= 6'h00;
            r_snap       <= 20'h00000;
            r_pend_snap  <= 20'h00000;
            r_frame_done <= 1'b0;
        end else begin
            r_active     <= w_active_nxt;
            r_pending    <= w_pending_nxt;
            r_snap       <= w_snap_nxt;
            r_pend_snap  <= w_pend_snap_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // Request fields are forced to zero whenever no request is presented.
    always_comb begin
        o_draw_valid = (r_state == SEND);
        o_draw_idx   = o_draw_valid ? w_idx : 3'd0;
        o_draw_value = o_draw_valid ? w_value : 4'd0;
        o_draw_x     = o_draw_valid ? digitX(w_idx) : '0;
        o_busy       = (r_state == SEND) || (r_pending != 6'h00);
        o_frame_done = r_frame_done;
    end

endmodule
